// File: rtl/s2_pkg.sv
// rtl/s2_pkg.sv - shared stage-2 operand memory geometry and loader state encoding
package s2_pkg;

    localparam int S2_WORDS_PER_BANK = 36;
    localparam int S2_NUM_BANKS      = 4;
    localparam int S2_ADDR_W         = 6;
    localparam int S2_BANK_W         = 2;

    typedef enum logic [1:0] {
        LOAD      = 2'd0,
        FLUSH     = 2'd1,
        HANDOFF   = 2'd2,
        WAIT_DONE = 2'd3
    } loader_state_t;

endpackage

// File: rtl/s2_bank_addr_gen.sv
// rtl/s2_bank_addr_gen.sv - nested word/bank address counter for bank-major operand writes
module s2_bank_addr_gen
    import s2_pkg::*;
#(
    parameter int WORDS_PER_BANK = S2_WORDS_PER_BANK,
    parameter int NUM_BANKS      = S2_NUM_BANKS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 inc,
    input  logic                 clear,
    output logic [S2_ADDR_W-1:0] addr,
    output logic [S2_BANK_W-1:0] bank,
    output logic                 last
);

    localparam logic [S2_ADDR_W-1:0] ADDR_MAX = S2_ADDR_W'(WORDS_PER_BANK - 1);
    localparam logic [S2_BANK_W-1:0] BANK_MAX = S2_BANK_W'(NUM_BANKS - 1);

    logic addr_last;

    assign addr_last = (addr == ADDR_MAX);
    assign last      = addr_last && (bank == BANK_MAX);

    // clear wins over inc so a non-power-of-two bank count still restarts at bank 0
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            addr <= '0;
            bank <= '0;
        end else if (inc) begin
            if (addr_last) begin
                addr <= '0;
                bank <= bank + 1'b1;
            end else begin
                addr <= addr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/s2_bank_loader.sv
// rtl/s2_bank_loader.sv - streams one frame into the stage-2 operand banks and hands it off
module s2_bank_loader
    import s2_pkg::*;
#(
    parameter int DATA_W         = 16,
    parameter int WORDS_PER_BANK = S2_WORDS_PER_BANK,
    parameter int NUM_BANKS      = S2_NUM_BANKS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic [DATA_W-1:0]    in_data,
    output logic                 in_ready,
    input  logic                 busy_proc,
    output logic                 wr_en,
    output logic [S2_BANK_W-1:0] wr_bank,
    output logic [S2_ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0]    wr_data,
    output logic                 data_rdy,
    output logic                 busy_load,
    output logic [7:0]           frame_cnt
);

    loader_state_t        state;
    logic                 accept;
    logic                 frame_last;
    logic [S2_ADDR_W-1:0] addr;
    logic [S2_BANK_W-1:0] bank;

    assign accept = in_valid && in_ready;

    s2_bank_addr_gen #(
        .WORDS_PER_BANK (WORDS_PER_BANK),
        .NUM_BANKS      (NUM_BANKS)
    ) u_addr_gen (
        .clk   (clk),
        .reset (reset),
        .inc   (accept),
        .clear (accept && frame_last),
        .addr  (addr),
        .bank  (bank),
        .last  (frame_last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_en   <= 1'b0;
            wr_bank <= '0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            wr_en <= accept;
            if (accept) begin
                wr_bank <= bank;
                wr_addr <= addr;
                wr_data <= in_data;
            end
        end
    end

    // Flags are registered alongside the state so each output follows the state it names.
    // FLUSH exists only to let the final write reach memory before data_rdy is raised.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= LOAD;
            in_ready  <= 1'b1;
            data_rdy  <= 1'b0;
            busy_load <= 1'b0;
            frame_cnt <= '0;
        end else begin
            case (state)
                LOAD: begin
                    if (accept && frame_last) begin
                        state     <= FLUSH;
                        in_ready  <= 1'b0;
                        busy_load <= 1'b1;
                    end
                end
                FLUSH: begin
                    state    <= HANDOFF;
                    data_rdy <= 1'b1;
                end
                HANDOFF: begin
                    // drop the request as soon as the consumer starts so it cannot rerun
                    if (busy_proc) begin
                        state     <= WAIT_DONE;
                        data_rdy  <= 1'b0;
                        frame_cnt <= frame_cnt + 8'd1;
                    end
                end
                WAIT_DONE: begin
                    if (!busy_proc) begin
                        state     <= LOAD;
                        in_ready  <= 1'b1;
                        busy_load <= 1'b0;
                    end
                end
                default: begin
                    state     <= LOAD;
                    in_ready  <= 1'b1;
                    data_rdy  <= 1'b0;
                    busy_load <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_s2_bank_loader.sv
// tb/tb_s2_bank_loader.sv - directed self-checking bench for s2_bank_loader
module tb_s2_bank_loader;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_ready;
    logic        busy_proc;
    logic        wr_en;
    logic [1:0]  wr_bank;
    logic [5:0]  wr_addr;
    logic [15:0] wr_data;
    logic        data_rdy;
    logic        busy_load;
    logic [7:0]  frame_cnt;

    int checks;
    int errors;

    s2_bank_loader dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .busy_proc (busy_proc),
        .wr_en     (wr_en),
        .wr_bank   (wr_bank),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .data_rdy  (data_rdy),
        .busy_load (busy_load),
        .frame_cnt (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; in_data = '0; busy_proc = 1'b0;
        step(); step();
        reset = 1'b0;
        checks++;
        if ({wr_en, wr_bank, wr_addr, wr_data} !== 25'd0) begin
            errors++; $display("FAIL reset_wr: got %b/%0d/%0d/%h expected 0/0/0/0", wr_en, wr_bank, wr_addr, wr_data);
        end
        checks++;
        if ({data_rdy, busy_load, frame_cnt} !== 10'd0) begin
            errors++; $display("FAIL reset_flags: got rdy=%b busy=%b cnt=%0d expected 0/0/0", data_rdy, busy_load, frame_cnt);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_stream();
        for (int i = 0; i < 144; i++) begin
            checks++;
            if (in_ready !== 1'b1) begin
                errors++; $display("FAIL stream_in_ready word %0d: got %b expected 1", i, in_ready);
            end
            in_valid = 1'b1; in_data = 16'(i);
            step();
            checks++;
            if (wr_en !== 1'b1 || wr_bank !== 2'(i / 36) || wr_addr !== 6'(i % 36) || wr_data !== 16'(i)) begin
                errors++; $display("FAIL stream_write word %0d: got en=%b bank=%0d addr=%0d data=%0d expected 1/%0d/%0d/%0d",
                                   i, wr_en, wr_bank, wr_addr, wr_data, i / 36, i % 36, i);
            end
            checks++;
            if (data_rdy !== 1'b0) begin
                errors++; $display("FAIL stream_early_rdy word %0d: got %b expected 0", i, data_rdy);
            end
        end
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0 || busy_load !== 1'b1) begin
            errors++; $display("FAIL flush_state: got ready=%b busy_load=%b expected 0/1", in_ready, busy_load);
        end
        step();
        checks++;
        if (data_rdy !== 1'b1 || wr_en !== 1'b0) begin
            errors++; $display("FAIL rdy_latency: got rdy=%b wr_en=%b expected 1/0 at t+2", data_rdy, wr_en);
        end
    endtask

    task automatic test_hold();
        in_valid = 1'b1; in_data = 16'hBEEF;
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if (data_rdy !== 1'b1 || in_ready !== 1'b0 || wr_en !== 1'b0) begin
                errors++; $display("FAIL hold cycle %0d: got rdy=%b ready=%b wr_en=%b expected 1/0/0", i, data_rdy, in_ready, wr_en);
            end
        end
    endtask

    task automatic test_handoff();
        busy_proc = 1'b1;
        step();
        checks++;
        if (data_rdy !== 1'b0 || frame_cnt !== 8'd1) begin
            errors++; $display("FAIL handoff_ack: got rdy=%b cnt=%0d expected 0/1", data_rdy, frame_cnt);
        end
        for (int i = 1; i < 144; i++) begin
            step();
            checks++;
            if (in_ready !== 1'b0 || data_rdy !== 1'b0 || wr_en !== 1'b0) begin
                errors++; $display("FAIL wait_done cycle %0d: got ready=%b rdy=%b wr_en=%b expected 0/0/0", i, in_ready, data_rdy, wr_en);
            end
        end
        busy_proc = 1'b0; in_valid = 1'b0;
        step();
        checks++;
        if (in_ready !== 1'b1 || busy_load !== 1'b0 || frame_cnt !== 8'd1) begin
            errors++; $display("FAIL release: got ready=%b busy_load=%b cnt=%0d expected 1/0/1", in_ready, busy_load, frame_cnt);
        end
    endtask

    task automatic test_toggle();
        int writes;
        writes = 0;
        for (int k = 0; k < 288; k++) begin
            in_valid = (k % 2 == 0);
            in_data  = 16'h1000 + 16'(k / 2);
            step();
            checks++;
            if (k % 2 == 0) begin
                if (wr_en !== 1'b1 || wr_bank !== 2'((k / 2) / 36) || wr_addr !== 6'((k / 2) % 36) || wr_data !== 16'h1000 + 16'(k / 2)) begin
                    errors++; $display("FAIL toggle_write word %0d: got en=%b bank=%0d addr=%0d data=%h expected 1/%0d/%0d/%h",
                                       k / 2, wr_en, wr_bank, wr_addr, wr_data, (k / 2) / 36, (k / 2) % 36, 16'h1000 + 16'(k / 2));
                end
            end else if (wr_en !== 1'b0) begin
                errors++; $display("FAIL toggle_idle cycle %0d: got wr_en=%b expected 0", k, wr_en);
            end
            if (wr_en === 1'b1) writes++;
        end
        in_valid = 1'b0;
        checks++;
        if (writes !== 144) begin
            errors++; $display("FAIL toggle_count: got %0d writes expected 144", writes);
        end
        checks++;
        if (data_rdy !== 1'b1) begin
            errors++; $display("FAIL toggle_rdy: got %b expected 1", data_rdy);
        end
        busy_proc = 1'b1; step();
        busy_proc = 1'b0; step();
        checks++;
        if (frame_cnt !== 8'd2 || in_ready !== 1'b1) begin
            errors++; $display("FAIL toggle_handoff: got cnt=%0d ready=%b expected 2/1", frame_cnt, in_ready);
        end
    endtask

    task automatic test_busy_early();
        busy_proc = 1'b1;
        for (int i = 0; i < 144; i++) begin
            checks++;
            if (in_ready !== 1'b1) begin
                errors++; $display("FAIL early_busy_ready word %0d: got %b expected 1", i, in_ready);
            end
            in_valid = 1'b1; in_data = 16'h4000 + 16'(i);
            step();
        end
        in_valid = 1'b0;
        step();
        checks++;
        if (data_rdy !== 1'b1) begin
            errors++; $display("FAIL early_busy_rdy: got %b expected 1", data_rdy);
        end
        step();
        checks++;
        if (data_rdy !== 1'b0 || frame_cnt !== 8'd3) begin
            errors++; $display("FAIL early_busy_one_cycle: got rdy=%b cnt=%0d expected 0/3", data_rdy, frame_cnt);
        end
        busy_proc = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 50; i++) begin
            in_valid = 1'b1; in_data = 16'h2000 + 16'(i);
            step();
        end
        in_valid = 1'b0; reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if (wr_en !== 1'b0 || in_ready !== 1'b1 || data_rdy !== 1'b0) begin
            errors++; $display("FAIL mid_reset_state: got en=%b ready=%b rdy=%b expected 0/1/0", wr_en, in_ready, data_rdy);
        end
        for (int i = 0; i < 144; i++) begin
            in_valid = 1'b1; in_data = 16'h3000 + 16'(i);
            step();
            if (i == 0) begin
                checks++;
                if (wr_bank !== 2'd0 || wr_addr !== 6'd0 || wr_data !== 16'h3000) begin
                    errors++; $display("FAIL mid_reset_restart: got bank=%0d addr=%0d data=%h expected 0/0/3000", wr_bank, wr_addr, wr_data);
                end
            end
            checks++;
            if (data_rdy !== 1'b0) begin
                errors++; $display("FAIL mid_reset_partial_rdy word %0d: got %b expected 0", i, data_rdy);
            end
        end
        in_valid = 1'b0;
        step();
        checks++;
        if (data_rdy !== 1'b1) begin
            errors++; $display("FAIL mid_reset_frame_rdy: got %b expected 1", data_rdy);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if (data_rdy !== 1'b0 || frame_cnt !== 8'd0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL handoff_reset: got rdy=%b cnt=%0d ready=%b expected 0/0/1", data_rdy, frame_cnt, in_ready);
        end
    endtask

    task automatic test_wrap();
        for (int f = 0; f < 256; f++) begin
            for (int i = 0; i < 144; i++) begin
                in_valid = 1'b1; in_data = 16'(f * 144 + i);
                step();
            end
            checks++;
            if (wr_bank !== 2'd3 || wr_addr !== 6'd35 || wr_data !== 16'(f * 144 + 143)) begin
                errors++; $display("FAIL wrap_last_write frame %0d: got bank=%0d addr=%0d data=%h expected 3/35/%h",
                                   f, wr_bank, wr_addr, wr_data, 16'(f * 144 + 143));
            end
            in_data = 16'hDEAD;
            step();
            step();
            checks++;
            if (data_rdy !== 1'b1 || in_ready !== 1'b0 || wr_en !== 1'b0) begin
                errors++; $display("FAIL wrap_handoff frame %0d: got rdy=%b ready=%b wr_en=%b expected 1/0/0", f, data_rdy, in_ready, wr_en);
            end
            busy_proc = 1'b1;
            step();
            step();
            checks++;
            if (frame_cnt !== 8'((f + 1) % 256) || wr_en !== 1'b0 || in_ready !== 1'b0) begin
                errors++; $display("FAIL wrap_wait frame %0d: got cnt=%0d wr_en=%b ready=%b expected %0d/0/0",
                                   f, frame_cnt, wr_en, in_ready, (f + 1) % 256);
            end
            busy_proc = 1'b0; in_valid = 1'b0;
            step();
        end
        checks++;
        if (frame_cnt !== 8'd0) begin
            errors++; $display("FAIL wrap_final: got %0d expected 0", frame_cnt);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_stream();
        test_hold();
        test_handoff();
        test_toggle();
        test_busy_early();
        test_reset_mid();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/s2_bank_loader.md
Name: s2_bank_loader

Overview:
- Write-side front end of the stage-2 multiply engine.
- Accepts a valid/ready input stream and writes NUM_BANKS x WORDS_PER_BANK words into the stage-2 operand memory, bank-major, using (wr_bank, wr_addr).
- When the frame is complete, it raises data_rdy to the stage-2 control FSM. It then refuses new data until that FSM has started (busy_proc=1) and finished (busy_proc=0), so the memory is never overwritten mid-read.

Parameters:
- DATA_W, 16: input and write-data width.
- WORDS_PER_BANK, 36: words per bank; wr_addr runs 0..35.
- NUM_BANKS, 4: banks per frame; wr_bank runs 0..3.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  input word valid
- in_data  in  DATA_W  input word
- in_ready  out  1  loader can accept a word
- busy_proc  in  1  stage-2 control FSM busy
- wr_en  out  1  operand-memory write strobe
- wr_bank  out  2  bank select (0..3)
- wr_addr  out  6  word address within bank (0..35)
- wr_data  out  DATA_W  write data
- data_rdy  out  1  frame complete, request processing
- busy_load  out  1  high whenever state != LOAD
- frame_cnt  out  8  frames handed off, wraps 255->0

Behaviour:
- Clock and reset: one clock (clk). reset is synchronous and active-high.
- Reset values: state=LOAD, bank/addr counters=0, wr_en=0, wr_bank=0, wr_addr=0, wr_data=0, data_rdy=0, frame_cnt=0, busy_load=0.
- Accept condition: a word is accepted on a cycle with in_valid && in_ready.
- States:
  - LOAD:
    - in_ready=1.
    - On accept: wr_en=1, wr_bank/wr_addr = current counters, wr_data = in_data, all registered and visible the cycle after accept. wr_en is 0 the cycle after a non-accept cycle.
    - Counter advance: addr increments on accept. At addr==WORDS_PER_BANK-1, addr returns to 0 and bank increments.
    - Frame end: accepting bank==NUM_BANKS-1 with addr==WORDS_PER_BANK-1 moves to FLUSH, and both counters clear to 0.
  - FLUSH (1 cycle):
    - in_ready=0.
    - The final write is on the wr_* outputs this cycle.
    - Next state is HANDOFF. The last write therefore commits before data_rdy is seen.
  - HANDOFF:
    - in_ready=0, data_rdy=1 (Moore output).
    - Stays until busy_proc==1, then goes to WAIT_DONE and increments frame_cnt.
    - data_rdy stays level, not a pulse, until busy_proc is seen high. It then drops, so the consumer cannot restart on its return to idle.
  - WAIT_DONE:
    - in_ready=0, data_rdy=0.
    - When busy_proc==0, go to LOAD.
    - The first new word may be accepted the cycle after leaving WAIT_DONE.
- busy_proc high while in LOAD or FLUSH: ignored, no error.
- busy_proc high already on HANDOFF entry: leaves after exactly one data_rdy cycle.
- in_valid while in_ready=0: no accept, no write. Upstream holds its data.
- Reset mid-frame or mid-handoff: partial frame is discarded, data_rdy drops on the next cycle, and loading restarts at bank 0, addr 0.
- Latency: from the accept of the last word (cycle t), data_rdy first goes high at t+2.
- Minimum frame period: 144 accepts + 1 (FLUSH) + handoff + consumer run time.

Decomposition:
- Package s2_pkg holds:
  - the enum loader_state_t {LOAD, FLUSH, HANDOFF, WAIT_DONE} (2-bit);
  - localparams S2_WORDS_PER_BANK=36, S2_NUM_BANKS=4, S2_ADDR_W=6, S2_BANK_W=2, shared with the stage-2 control FSM.
- One natural sub-module: s2_bank_addr_gen, the nested addr/bank counter with inc, clear and last outputs.

Test Plan:
- Reset, then stream 144 words (value = index, in_valid constant) -> wr_* as follows:
  - word 0 at bank0/addr0; word 35 at bank0/addr35; word 36 at bank1/addr0; word 143 at bank3/addr35.
  - data_rdy rises 2 cycles after the last accept.
- Hold busy_proc=0 for 10 cycles after data_rdy -> data_rdy stays 1 and in_ready stays 0 throughout.
- Raise busy_proc for 144 cycles, then drop it -> data_rdy falls the cycle after busy_proc is seen, frame_cnt becomes 1, in_ready returns 1 the cycle after busy_proc falls.
- in_valid toggling 1/0 every cycle -> exactly 144 writes with no gaps or duplicates in addresses, and wr_en=0 on idle cycles.
- Assert reset after 50 accepts -> next accepted word is written at bank0/addr0, with no data_rdy from the partial frame.
- Run 256 complete frames -> frame_cnt wraps to 0, and in_valid is ignored throughout every HANDOFF/WAIT_DONE period.
